// File: rtl/lii_mem_target.sv
// LII memory target: serves single-request read/write bursts against a local word memory.
// Optional macro LII_TGT_BOUNDS_CHECK_EN rejects headers outside the memory or with size != 3.
module lii_mem_target #(
    parameter int AXI_AW = 48,
    parameter int AXI_DW = 64,
    parameter int LII_DW = 128,
    parameter int MEM_AW = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [LII_DW-1:0]   lii_req_tdata,
    input  logic [LII_DW/8-1:0] lii_req_tkeep,
    input  logic [LII_DW/8-1:0] lii_req_tstrb,
    input  logic                lii_req_tlast,
    input  logic [7:0]          lii_req_src,
    input  logic [7:0]          lii_req_dst,
    input  logic                lii_req_tvalid,
    output logic                lii_req_tready,
    output logic [LII_DW-1:0]   lii_resp_tdata,
    output logic [LII_DW/8-1:0] lii_resp_tkeep,
    output logic [LII_DW/8-1:0] lii_resp_tstrb,
    output logic                lii_resp_tlast,
    output logic [7:0]          lii_resp_src,
    output logic [7:0]          lii_resp_dst,
    output logic                lii_resp_tvalid,
    input  logic                lii_resp_tready,
    input  logic [7:0]          cfg_src
);
    localparam int ADDR_LSB = 67;
    localparam int ADDR_MSB = ADDR_LSB + AXI_AW - 1;

    typedef enum logic [2:0] {S_HDR, S_RD, S_WR, S_ACK, S_DRAIN} state_t;
    state_t state, state_nx;

    logic              rdy_en;
    logic [7:0]        len, hdr_src;
    logic [MEM_AW-1:0] idx;
    logic              oor, hdr_oor;
    logic [8:0]        cnt;
    logic [7:0]        out_cnt;
    logic [1:0]        resp;
    logic              vld_p1;
    logic [AXI_DW-1:0] rd_data_p1;
    logic [AXI_DW-1:0] buf_q [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        occ;
    logic [2:0]        load;
    logic [AXI_DW-1:0] mem [1 << MEM_AW];

    logic hs_req, hs_hdr, wr_beat, pop, pop_rd, rd_issue, mem_we, resp_vld;
    logic unused_ok;

    assign unused_ok = ^{lii_req_tkeep, lii_req_dst, lii_req_tstrb, lii_req_tdata,
                         lii_req_tdata[ADDR_MSB:ADDR_LSB]};

`ifdef LII_TGT_BOUNDS_CHECK_EN
    assign hdr_oor = (lii_req_tdata[ADDR_MSB:ADDR_LSB+MEM_AW+3] != '0) ||
                     (lii_req_tdata[117:115] != 3'd3);
`else
    assign hdr_oor = 1'b0;
`endif

    assign lii_req_tready = rdy_en && (state == S_HDR || state == S_WR || state == S_DRAIN);
    assign hs_req   = lii_req_tvalid && lii_req_tready;
    assign hs_hdr   = hs_req && (state == S_HDR);
    assign wr_beat  = hs_req && (state == S_WR);
    assign mem_we   = wr_beat && (cnt <= {1'b0, len}) && !oor;
    assign pop      = resp_vld && lii_resp_tready;
    assign pop_rd   = pop && (state == S_RD);
    // Count the beat leaving this cycle so back-to-back reads keep one beat per cycle.
    assign load     = {1'b0, occ} + {2'b0, vld_p1} - {2'b0, pop_rd};
    assign rd_issue = (state == S_RD) && (cnt <= {1'b0, len}) && (load < 3'd2);

    always_comb begin
        state_nx = state;
        case (state)
            S_HDR: if (hs_req) begin
                case (lii_req_tdata[127:126])
                    2'b00:   state_nx = S_RD;
                    2'b01:   state_nx = S_WR;
                    default: state_nx = lii_req_tlast ? S_HDR : S_DRAIN;
                endcase
            end
            S_RD:    if (pop_rd && out_cnt == len) state_nx = S_HDR;
            S_WR:    if (hs_req && lii_req_tlast) state_nx = S_ACK;
            S_ACK:   if (pop) state_nx = S_HDR;
            S_DRAIN: if (hs_req && lii_req_tlast) state_nx = S_HDR;
            default: state_nx = S_HDR;
        endcase
    end

    always_comb begin
        resp_vld       = 1'b0;
        lii_resp_tdata = '0;
        lii_resp_tkeep = '0;
        lii_resp_tstrb = '0;
        lii_resp_tlast = 1'b0;
        if (state == S_ACK) begin
            resp_vld            = 1'b1;
            lii_resp_tdata[1:0] = resp;
            lii_resp_tlast      = 1'b1;
        end else if (state == S_RD && occ != 2'd0) begin
            resp_vld                   = 1'b1;
            lii_resp_tdata[AXI_DW-1:0] = buf_q[rd_ptr];
            lii_resp_tkeep             = '1;
            lii_resp_tstrb             = '1;
            lii_resp_tlast             = (out_cnt == len);
        end
    end

    assign lii_resp_tvalid = resp_vld;
    assign lii_resp_src    = resp_vld ? cfg_src : 8'h00;
    assign lii_resp_dst    = resp_vld ? hdr_src : 8'h00;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_HDR;
            rdy_en  <= 1'b0;
            len     <= '0;
            hdr_src <= '0;
            idx     <= '0;
            oor     <= 1'b0;
            cnt     <= '0;
            out_cnt <= '0;
            resp    <= '0;
            vld_p1  <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= '0;
        end else begin
            state  <= state_nx;
            rdy_en <= 1'b1;
            if (hs_hdr) begin
                len     <= lii_req_tdata[125:118];
                hdr_src <= lii_req_src;
                idx     <= lii_req_tdata[ADDR_LSB+MEM_AW+2:ADDR_LSB+3];
                oor     <= hdr_oor;
                cnt     <= '0;
                out_cnt <= '0;
                resp    <= 2'b00;
            end
            if (rd_issue) begin
                cnt <= cnt + 9'd1;
                idx <= idx + MEM_AW'(1);
            end
            if (wr_beat) begin
                // Beats past the burst length are swallowed without advancing.
                if (cnt <= {1'b0, len}) begin
                    cnt <= cnt + 9'd1;
                    idx <= idx + MEM_AW'(1);
                end
                if (lii_req_tlast)
                    resp <= (oor || cnt < {1'b0, len}) ? 2'b10 : 2'b00;
            end
            vld_p1 <= rd_issue;
            if (pop_rd) begin
                rd_ptr  <= ~rd_ptr;
                out_cnt <= out_cnt + 8'd1;
            end
            if (vld_p1) wr_ptr <= ~wr_ptr;
            occ <= occ + {1'b0, vld_p1} - {1'b0, pop_rd};
        end
    end

    // p0: memory access; p1: registered read word enters the response buffer
    always_ff @(posedge clk) begin
        if (rd_issue) rd_data_p1 <= mem[idx];
        if (mem_we) begin
            for (int b = 0; b < AXI_DW / 8; b++)
                if (lii_req_tstrb[b]) mem[idx][b*8 +: 8] <= lii_req_tdata[b*8 +: 8];
        end
        if (vld_p1) buf_q[wr_ptr] <= oor ? '0 : rd_data_p1;
    end

endmodule

// File: tb/tb_lii_mem_target.sv
// Directed bench for lii_mem_target: table of read/write bursts plus drain and reset sequences.
module tb_lii_mem_target;
    localparam int MAW = 10;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [127:0] req_tdata = '0;
    logic [15:0]  req_tkeep = '0, req_tstrb = '0;
    logic         req_tlast = 1'b0;
    logic [7:0]   req_src = '0, req_dst = '0;
    logic         req_tvalid = 1'b0;
    logic         req_tready;
    logic [127:0] resp_tdata;
    logic [15:0]  resp_tkeep, resp_tstrb;
    logic         resp_tlast;
    logic [7:0]   resp_src, resp_dst;
    logic         resp_tvalid;
    logic         resp_tready = 1'b0;
    logic [7:0]   cfg_src = 8'h5A;

    always #5 clk = ~clk;

    lii_mem_target dut (
        .clk(clk), .rstn(rstn),
        .lii_req_tdata(req_tdata), .lii_req_tkeep(req_tkeep), .lii_req_tstrb(req_tstrb),
        .lii_req_tlast(req_tlast), .lii_req_src(req_src), .lii_req_dst(req_dst),
        .lii_req_tvalid(req_tvalid), .lii_req_tready(req_tready),
        .lii_resp_tdata(resp_tdata), .lii_resp_tkeep(resp_tkeep), .lii_resp_tstrb(resp_tstrb),
        .lii_resp_tlast(resp_tlast), .lii_resp_src(resp_src), .lii_resp_dst(resp_dst),
        .lii_resp_tvalid(resp_tvalid), .lii_resp_tready(resp_tready),
        .cfg_src(cfg_src)
    );

    int nvec = 0, nmis = 0;
    logic [63:0] model [1024];

`ifdef LII_TGT_BOUNDS_CHECK_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    typedef struct {
        logic        wr;
        logic [7:0]  len;
        logic [47:0] addr;
        int          nb;
        logic [63:0] base;
        logic [7:0]  strb;
        logic [1:0]  resp;
        logic        tog;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    function automatic logic model_oor(input logic [47:0] a);
        logic hi;
        hi = (a[47:MAW+3] != '0);
`ifdef LII_TGT_BOUNDS_CHECK_EN
        return hi;
`else
        return 1'b0 & hi;
`endif
    endfunction

    function automatic logic [127:0] hdr(input logic [1:0] op, input logic [7:0] len,
                                         input logic [47:0] addr);
        logic [127:0] d;
        d = '0;
        d[127:126] = op;
        d[125:118] = len;
        d[117:115] = 3'd3;
        d[114:67]  = addr;
        d[66:59]   = 8'hC3;
        return d;
    endfunction

    task automatic send(input logic [127:0] d, input logic [15:0] s, input logic l,
                        input logic [7:0] src);
        int n;
        req_tdata = d; req_tstrb = s; req_tkeep = s; req_tlast = l;
        req_src = src; req_dst = 8'h01; req_tvalid = 1'b1;
        n = 0;
        while (!req_tready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) chk("req_accept_timeout", 128'(req_tready), 128'(1'b1));
        @(posedge clk); #1;
        req_tvalid = 1'b0; req_tlast = 1'b0;
    endtask

    task automatic get_ack(input logic [1:0] exp, input logic [7:0] src);
        int n;
        resp_tready = 1'b1;
        n = 0;
        while (!resp_tvalid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ack_valid", 128'(resp_tvalid), 128'(1'b1));
        chk("ack_resp", 128'(resp_tdata[1:0]), 128'(exp));
        chk("ack_upper_zero", 128'(resp_tdata[127:2]), 128'(0));
        chk("ack_keep_strb", 128'({resp_tkeep, resp_tstrb}), 128'(0));
        chk("ack_last", 128'(resp_tlast), 128'(1'b1));
        chk("ack_src_dst", 128'({resp_src, resp_dst}), 128'({cfg_src, src}));
        @(posedge clk); #1;
        chk("ack_single", 128'(resp_tvalid), 128'(1'b0));
    endtask

    task automatic write_burst(input vec_t v, input logic [7:0] src);
        logic [9:0]  w;
        logic        o;
        logic [63:0] dat;
        o = model_oor(v.addr);
        w = v.addr[12:3];
        send(hdr(2'b01, v.len, v.addr), 16'h0, 1'b0, src);
        for (int i = 0; i < v.nb; i++) begin
            dat = v.base * 64'(i + 1);
            send({64'h0, dat}, {8'h00, v.strb}, (i == v.nb - 1), src);
            if (i <= int'(v.len) && !o) begin
                for (int b = 0; b < 8; b++)
                    if (v.strb[b]) model[w][b*8 +: 8] = dat[b*8 +: 8];
            end
            w++;
        end
        get_ack(v.resp, src);
    endtask

    task automatic read_burst(input vec_t v, input logic [7:0] src);
        logic [9:0]  w;
        logic        o;
        logic [63:0] e;
        int got, cyc, first;
        o = model_oor(v.addr);
        w = v.addr[12:3];
        resp_tready = 1'b0;
        send(hdr(2'b00, v.len, v.addr), 16'h0, 1'b1, src);
        got = 0; cyc = 0; first = 0;
        while (got <= int'(v.len) && cyc < 2000) begin
            resp_tready = v.tog ? (cyc % 3 == 0) : 1'b1;
            #1;
            if (resp_tvalid && resp_tready) begin
                e = o ? 64'h0 : model[w];
                chk("rd_data", resp_tdata, {64'h0, e});
                chk("rd_last", 128'(resp_tlast), 128'(got == int'(v.len)));
                chk("rd_keep_strb", 128'({resp_tkeep, resp_tstrb}), 128'(32'hFFFF_FFFF));
                chk("rd_src_dst", 128'({resp_src, resp_dst}), 128'({cfg_src, src}));
                if (got == 0) first = cyc;
                else if (!v.tog) chk("rd_cadence", 128'(cyc - first), 128'(got));
                w++;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rd_beat_count", 128'(got), 128'(int'(v.len) + 1));
        resp_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rd_no_extra", 128'(resp_tvalid), 128'(1'b0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [16];
        vec_t rv;
        vt[0]  = '{1'b1, 8'd3, 48'h40,          4, 64'h11,                  8'hFF, 2'b00, 1'b0};
        vt[1]  = '{1'b0, 8'd3, 48'h40,          0, 64'h0,                   8'h00, 2'b00, 1'b0};
        vt[2]  = '{1'b0, 8'd3, 48'h40,          0, 64'h0,                   8'h00, 2'b00, 1'b1};
        vt[3]  = '{1'b1, 8'd3, 48'h100,         4, 64'h01,                  8'hFF, 2'b00, 1'b0};
        vt[4]  = '{1'b1, 8'd3, 48'h100,         2, 64'hA5,                  8'hFF, 2'b10, 1'b0};
        vt[5]  = '{1'b0, 8'd3, 48'h100,         0, 64'h0,                   8'h00, 2'b00, 1'b0};
        vt[6]  = '{1'b1, 8'd0, 48'h48,          1, 64'hDEADBEEF_CAFEF00D,   8'h0F, 2'b00, 1'b0};
        vt[7]  = '{1'b0, 8'd1, 48'h48,          0, 64'h0,                   8'h00, 2'b00, 1'b1};
        vt[8]  = '{1'b1, 8'd1, 48'h1FF8,        2, 64'h77,                  8'hFF, 2'b00, 1'b0};
        vt[9]  = '{1'b0, 8'd1, 48'h1FF8,        0, 64'h0,                   8'h00, 2'b00, 1'b0};
        vt[10] = '{1'b1, 8'd3, 48'h80,          4, 64'h1000,                8'hFF, 2'b00, 1'b0};
        vt[11] = '{1'b1, 8'd1, 48'h80,          4, 64'h2000,                8'hFF, 2'b00, 1'b0};
        vt[12] = '{1'b0, 8'd3, 48'h80,          0, 64'h0,                   8'h00, 2'b00, 1'b0};
        vt[13] = '{1'b1, 8'd3, 48'h1_0000_0040, 4, 64'h5,                   8'hFF, OOR_RESP, 1'b0};
        vt[14] = '{1'b0, 8'd3, 48'h1_0000_0040, 0, 64'h0,                   8'h00, 2'b00, 1'b1};
        vt[15] = '{1'b0, 8'd3, 48'h40,          0, 64'h0,                   8'h00, 2'b00, 1'b0};

        // Reset state and first-cycle ready.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 128'(req_tready), 128'(1'b0));
        chk("rst_tvalid", 128'(resp_tvalid), 128'(1'b0));
        chk("rst_resp_fields", {resp_tdata}, 128'(0));
        rstn = 1'b1;
        chk("rel_tready_low", 128'(req_tready), 128'(1'b0));
        @(posedge clk); #1;
        chk("rel_tready_high", 128'(req_tready), 128'(1'b1));

        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) write_burst(vt[i], 8'h30 + 8'(i));
            else          read_burst(vt[i], 8'h30 + 8'(i));
        end

        // Reserved opcode: multi-flit drain, then single-flit header that stays idle.
        send(hdr(2'b10, 8'd1, 48'h0), 16'h0, 1'b0, 8'h61);
        send(128'hFFFF, 16'hFFFF, 1'b0, 8'h61);
        send(hdr(2'b01, 8'd0, 48'h40), 16'hFFFF, 1'b1, 8'h61);
        chk("drain_no_resp", 128'(resp_tvalid), 128'(1'b0));
        chk("drain_ready", 128'(req_tready), 128'(1'b1));
        send(hdr(2'b11, 8'd0, 48'h0), 16'h0, 1'b1, 8'h62);
        chk("op11_no_resp", 128'(resp_tvalid), 128'(1'b0));
        rv = '{1'b0, 8'd3, 48'h40, 0, 64'h0, 8'h00, 2'b00, 1'b0};
        read_burst(rv, 8'h63);

        // Reset in the middle of a len=7 write burst.
        rv = '{1'b1, 8'd7, 48'h200, 8, 64'h0, 8'hFF, 2'b00, 1'b0};
        send(hdr(2'b01, 8'd7, 48'h200), 16'h0, 1'b0, 8'h70);
        send({64'h0, 64'h0BAD_0001}, 16'h00FF, 1'b0, 8'h70);
        send({64'h0, 64'h0BAD_0002}, 16'h00FF, 1'b0, 8'h70);
        model[10'h40] = 64'h0BAD_0001;
        model[10'h41] = 64'h0BAD_0002;
        req_tdata = {64'h0, 64'h0BAD_0003}; req_tstrb = 16'h00FF; req_tvalid = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_tvalid", 128'(resp_tvalid), 128'(1'b0));
        chk("midrst_tready", 128'(req_tready), 128'(1'b0));
        req_tvalid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("midrst_rel_low", 128'(req_tready), 128'(1'b0));
        @(posedge clk); #1;
        chk("midrst_rel_high", 128'(req_tready), 128'(1'b1));
        rv = '{1'b0, 8'd1, 48'h200, 0, 64'h0, 8'h00, 2'b00, 1'b0};
        read_burst(rv, 8'h71);
        rv = '{1'b1, 8'd1, 48'h300, 2, 64'h3C3C, 8'hFF, 2'b00, 1'b0};
        write_burst(rv, 8'h72);
        rv = '{1'b0, 8'd1, 48'h300, 0, 64'h0, 8'h00, 2'b00, 1'b1};
        read_burst(rv, 8'h73);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/lii_mem_target.md
LII_MEM_TARGET -- requirements
Module: lii_mem_target

Interface
REQ-001: Parameter AXI_AW, default 48, header address width.
REQ-002: Parameter AXI_DW, default 64, memory word and data-beat width.
REQ-003: Parameter LII_DW, default 128, LII flit width.
REQ-004: Parameter MEM_AW, default 10, memory word-address width (2^MEM_AW words of AXI_DW bits).
REQ-005: clk  input  1  single clock; all logic on rising edge.
REQ-006: rstn  input  1  reset, asynchronous assert, active-low.
REQ-007: lii_req_tdata/tkeep/tstrb/tlast/src/dst/tvalid  input  LII_DW/LII_DW/8/LII_DW/8/1/8/8/1  request flit stream.
REQ-008: lii_req_tready  output  1  request stream accept.
REQ-009: lii_resp_tdata/tkeep/tstrb/tlast/src/dst/tvalid  output  LII_DW/LII_DW/8/LII_DW/8/1/8/8/1  response flit stream.
REQ-010: lii_resp_tready  input  1  response stream accept.
REQ-011: cfg_src  input  8  this target's node ID, driven on lii_resp_src.

Function
REQ-012: Header flit decode: op=tdata[127:126] (00 read, 01 write), len=[125:118], size=[117:115], addr=[114:67], tag=[66:59]; burst = len+1 beats.
REQ-013: Word index = addr[MEM_AW+2:3]; each beat increments index by 1, wrapping modulo 2^MEM_AW.
REQ-014: FSM states S_HDR, S_RD, S_WR, S_ACK, S_DRAIN; reset state S_HDR.
REQ-015: S_HDR: tready=1; on header handshake latch len/addr/src; op 00 -> S_RD, op 01 -> S_WR, op 1x -> S_DRAIN (or stay S_HDR if tlast=1).
REQ-016: S_RD: tready=0; issue one synchronous memory read per cycle while (response-buffer occupancy + reads in flight) < 2; after len+1 reads issued and buffer empty -> S_HDR.
REQ-017: Read data lands in a 2-entry response buffer 1 cycle after issue; no read data lost or duplicated under any tready pattern.
REQ-018: Read response beat: tdata[63:0]=mem word, upper bits 0, tkeep=tstrb=all ones, tlast=1 on beat len only.
REQ-019: Sustained read throughput one beat per cycle when lii_resp_tready held 1.
REQ-020: S_WR: tready=1; each data handshake writes tdata[63:0] to current index with byte enables tstrb[7:0]; beat counter increments.
REQ-021: S_WR exit on data beat with tlast=1 -> S_ACK; beats after the (len+1)-th are accepted and discarded.
REQ-022: Early tlast (fewer than len+1 beats) ends burst; ack resp=SLVERR (10); otherwise resp=OKAY (00).
REQ-023: S_ACK: tready=0; drive single ack flit: tkeep=tstrb=0, tdata[1:0]=resp, rest 0, tlast=1; on handshake -> S_HDR.
REQ-024: S_DRAIN: tready=1, discard flits, on tlast handshake -> S_HDR; no response.
REQ-025: All responses: lii_resp_src=cfg_src, lii_resp_dst=latched header src.
REQ-026: Responses strictly in request order; only one request outstanding.

Reset
REQ-027: rstn low asynchronously forces S_HDR, buffer empty, counters 0, lii_resp_tvalid=0, lii_req_tready=0, all resp data/keep/strb/tlast/src/dst=0.
REQ-028: lii_req_tready rises to 1 on the first clock after rstn deasserts; memory contents not reset.
REQ-029: Reset mid-burst abandons the burst; already-written words retain their values.

Configuration
REQ-030: Macro LII_TGT_BOUNDS_CHECK_EN defined: header with addr bits above MEM_AW+2 nonzero, or size!=3, is out-of-range.
REQ-031: With macro: out-of-range write suppresses all memory writes, ack resp=SLVERR; out-of-range read returns len+1 beats of zero data.
REQ-032: Without macro: no check; addresses wrap modulo memory size, size ignored.

Verification
REQ-033: Write header len=3 addr=0x40, 4 beats 0x11..0x44 full strb -> one ack, keep=0, tdata[1:0]=00; words 8..11 hold 0x11..0x44.
REQ-034: Read header len=3 addr=0x40, tready=1 -> 4 beats 0x11..0x44 on consecutive cycles, tlast on 4th, dst=request src.
REQ-035: Same read with tready toggling 1,0,0,1,... -> identical 4 beats, none dropped or duplicated.
REQ-036: Write len=3 with tlast on 2nd beat -> ack resp=10; only 2 words written.
REQ-037: With LII_TGT_BOUNDS_CHECK_EN, write addr=0x1_0000_0000 -> ack resp=10, memory unchanged; read same addr -> zero beats.
REQ-038: rstn pulsed low during beat 2 of a len=7 write -> tvalid=0 immediately; next header accepted and served normally.
